bad_bullet_pool: RTL and testbench

Parametrised enemy-projectile engine holding N_BULLET independent bullet slots. It replaces the single-bullet enemy shooter.
- Spawns from the enemy position, advances every slot leftward once per game tick, and detects player collision (standing or squatting hitbox).
- Retires slots on hit or map exit.
- Sits in GameControl between the enemy AI (attack/defend) and the renderer/health logic (positions, hit pulse).

---
 rtl/game_pkg.sv | 43 ++++
 rtl/bad_bullet_slot.sv | 83 ++++++++
 rtl/bad_bullet_pool.sv | 117 +++++++++++
 tb/tb_bad_bullet_pool.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ============================================================================
// game_pkg : shared game geometry, bullet record and the hitbox overlap test
// Optional feature macro: BULLET_AIM_EN (vertical aiming of enemy bullets)
// Revision : 1.0
// ============================================================================
`default_nettype none

package game_pkg;

  localparam logic signed [12:0] MAP_X          = 13'sd600;
  localparam logic signed [12:0] MAP_Y          = 13'sd440;
  localparam logic signed [12:0] PLAYER_X       = 13'sd16;
  localparam logic signed [12:0] PLAYER_Y       = 13'sd32;
  localparam logic signed [12:0] SQUAT_PLAYER_Y = 13'sd16;
  localparam logic signed [12:0] BULLET_X       = 13'sd4;
  localparam logic signed [12:0] BULLET_Y       = 13'sd4;
  localparam logic signed [12:0] BULLET_STEP_X  = 13'sd8;
  localparam logic signed [12:0] BULLET_STEP_Y  = 13'sd2;

  typedef struct packed {
    logic signed [10:0] x;
    logic signed [9:0]  y;
    logic               act;
    logic signed [1:0]  dir;
  } bullet_t;

  // Overlap of a bullet box centred at (bx,by) with the player box of half-height hh.
  function automatic logic hit_box(
    input logic signed [12:0] bx,
    input logic signed [12:0] by,
    input logic signed [12:0] px,
    input logic signed [12:0] py,
    input logic signed [12:0] hh
  );
    return ((bx - BULLET_X) < (px + PLAYER_X)) &&
           ((bx + BULLET_X) > (px - PLAYER_X)) &&
           !((by - BULLET_Y) > (py + hh)) &&
           !((by + BULLET_Y) < (py - hh));
  endfunction

endpackage

`default_nettype wire

// File: rtl/bad_bullet_slot.sv
// ============================================================================
// bad_bullet_slot : one enemy bullet slot - load, move, map exit and player hit
// Optional feature macro: BULLET_AIM_EN (per-slot vertical direction)
// Revision : 1.0
// ============================================================================
`default_nettype none

module bad_bullet_slot
  import game_pkg::*;
#(
  parameter logic signed [12:0] STEP_X = BULLET_STEP_X
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              spawn_load,
  input  logic signed [10:0] spawn_x,
  input  logic signed [9:0] spawn_y,
`ifdef BULLET_AIM_EN
  input  logic signed [1:0] spawn_dir,
`endif
  input  logic signed [10:0] xPlayer,
  input  logic signed [9:0] yPlayer,
  input  logic              isQ,
  output bullet_t           bullet,
  output logic              hit
);

  logic signed [12:0] nx;
  logic signed [12:0] ny;
  logic signed [12:0] hh;
  logic               hit_now;
  logic               exit_now;

  always_comb begin
    nx = 13'($signed(bullet.x)) - STEP_X;
`ifdef BULLET_AIM_EN
    ny = 13'($signed(bullet.y)) + 13'($signed(bullet.dir)) * BULLET_STEP_Y;
    if (ny > (MAP_Y - BULLET_Y)) begin
      ny = MAP_Y - BULLET_Y;
    end else if (ny < (BULLET_Y - MAP_Y)) begin
      ny = BULLET_Y - MAP_Y;
    end
`else
    ny = 13'($signed(bullet.y));
`endif
    hh       = isQ ? SQUAT_PLAYER_Y : PLAYER_Y;
    hit_now  = hit_box(nx, ny, 13'(xPlayer), 13'(yPlayer), hh);
    exit_now = nx < (BULLET_X - MAP_X);
  end

  // A hit takes precedence over leaving the map so it is always reported.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bullet <= '0;
      hit    <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (tick) begin
        if (spawn_load) begin
          bullet.x   <= spawn_x;
          bullet.y   <= spawn_y;
          bullet.act <= 1'b1;
`ifdef BULLET_AIM_EN
          bullet.dir <= spawn_dir;
`endif
        end else if (bullet.act) begin
          bullet.x <= nx[10:0];
          bullet.y <= ny[9:0];
          if (hit_now) begin
            bullet.act <= 1'b0;
            hit        <= 1'b1;
          end else if (exit_now) begin
            bullet.act <= 1'b0;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bad_bullet_pool.sv
// ============================================================================
// bad_bullet_pool : N_BULLET enemy bullet slots with spawn priority and cooldown
// Optional feature macro: BULLET_AIM_EN (bullets steer vertically toward player)
// Revision : 1.0
// ============================================================================
`default_nettype none

module bad_bullet_pool
  import game_pkg::*;
#(
  parameter int                 N_BULLET = 4,
  parameter logic signed [12:0] STEP_X   = BULLET_STEP_X,
  parameter int                 COOLDOWN = 16,
  parameter int                 CD_W     = $clog2(COOLDOWN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    attack,
  input  logic                    defend,
  input  logic signed [10:0]      xEnemy,
  input  logic signed [9:0]       yEnemy,
  input  logic signed [10:0]      xPlayer,
  input  logic signed [9:0]       yPlayer,
  input  logic                    isQ,
  output logic [N_BULLET*11-1:0]  x,
  output logic [N_BULLET*10-1:0]  y,
  output logic [N_BULLET-1:0]     isE,
  output logic [N_BULLET-1:0]     hitMask,
  output logic                    isHit
);

  // COOLDOWN=0 gives a zero-width counter; keep at least one bit.
  localparam int CNT_W = (CD_W < 1) ? 1 : CD_W;

  logic [CNT_W-1:0]    cooldown;
  logic [N_BULLET-1:0] sel;
  logic [N_BULLET-1:0] load;
  logic                found;
  logic                spawn;
  logic signed [12:0]  spawn_x13;
`ifdef BULLET_AIM_EN
  logic signed [12:0]  dy;
  logic signed [1:0]   spawn_dir;
`endif

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_BULLET; i++) begin
      if (!isE[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    spawn     = tick && attack && !defend && (cooldown == '0) && found;
    load      = spawn ? sel : '0;
    spawn_x13 = 13'(xEnemy) - PLAYER_X - BULLET_X;
  end

`ifdef BULLET_AIM_EN
  always_comb begin
    dy = 13'(yPlayer) - 13'(yEnemy);
    if (dy > 13'sd0) begin
      spawn_dir = 2'sd1;
    end else if (dy < 13'sd0) begin
      spawn_dir = -2'sd1;
    end else begin
      spawn_dir = 2'sd0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cooldown <= '0;
    end else if (tick) begin
      if (spawn) begin
        cooldown <= CNT_W'(COOLDOWN);
      end else if (cooldown != '0) begin
        cooldown <= cooldown - CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < N_BULLET; i++) begin : g_slot
    bullet_t st;

    bad_bullet_slot #(
      .STEP_X (STEP_X)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .spawn_load (load[i]),
      .spawn_x    (spawn_x13[10:0]),
      .spawn_y    (yEnemy),
`ifdef BULLET_AIM_EN
      .spawn_dir  (spawn_dir),
`endif
      .xPlayer    (xPlayer),
      .yPlayer    (yPlayer),
      .isQ        (isQ),
      .bullet     (st),
      .hit        (hitMask[i])
    );

    assign x[11*i +: 11] = st.x;
    assign y[10*i +: 10] = st.y;
    assign isE[i]        = st.act;
  end

  assign isHit = |hitMask;

endmodule

`default_nettype wire

// File: tb/tb_bad_bullet_pool.sv
// Bench for bad_bullet_pool: two configurations checked every cycle against a
// slot-list model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
`default_nettype none

module tb_bad_bullet_pool;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0, tick = 1'b0, attack = 1'b0, defend = 1'b0, isQ = 1'b0;
  logic signed [10:0] xEnemy = '0, xPlayer = '0;
  logic signed [9:0]  yEnemy = '0, yPlayer = '0;

  logic [43:0] x_a;  logic [39:0] y_a;  logic [3:0] isE_a, hm_a;  logic ih_a;
  logic [21:0] x_b;  logic [19:0] y_b;  logic [1:0] isE_b, hm_b;  logic ih_b;

  always #5 clk = ~clk;

  bad_bullet_pool #(.N_BULLET(4), .COOLDOWN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .attack(attack), .defend(defend),
    .xEnemy(xEnemy), .yEnemy(yEnemy), .xPlayer(xPlayer), .yPlayer(yPlayer), .isQ(isQ),
    .x(x_a), .y(y_a), .isE(isE_a), .hitMask(hm_a), .isHit(ih_a));

  bad_bullet_pool #(.N_BULLET(2), .COOLDOWN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .attack(attack), .defend(defend),
    .xEnemy(xEnemy), .yEnemy(yEnemy), .xPlayer(xPlayer), .yPlayer(yPlayer), .isQ(isQ),
    .x(x_b), .y(y_b), .isE(isE_b), .hitMask(hm_b), .isHit(ih_b));

  // ---------------- behavioural model: a list of bullets per configuration
  int NB[2]  = '{4, 2};
  int CDM[2] = '{4, 0};
  int mx[2][8], my[2][8], mdir[2][8], mcd[2];
  bit mact[2][8], mhit[2][8];
  bit model_ok = 1'b0;

  int n_chk = 0, n_fail = 0;
  int hits_a = 0, hits_b = 0;
  logic [1:0] last_hm_b = '0;

  function automatic int wrap11(input int v);
    logic signed [10:0] t;
    t = v[10:0];
    return int'(t);
  endfunction

  function automatic int wrap10(input int v);
    logic signed [9:0] t;
    t = v[9:0];
    return int'(t);
  endfunction

  task automatic model_step(input int d);
    int fr, nx, ny, h, xp, yp, lim;
    fr  = -1;
    xp  = int'(xPlayer);
    yp  = int'(yPlayer);
    lim = int'(MAP_Y) - int'(BULLET_Y);
    h   = isQ ? int'(SQUAT_PLAYER_Y) : int'(PLAYER_Y);
    for (int i = 0; i < NB[d]; i++) mhit[d][i] = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < NB[d]; i++) begin
        mx[d][i] = 0; my[d][i] = 0; mdir[d][i] = 0; mact[d][i] = 1'b0;
      end
      mcd[d] = 0;
      return;
    end
    if (!tick) return;
    for (int i = NB[d] - 1; i >= 0; i--) if (!mact[d][i]) fr = i;
    for (int i = 0; i < NB[d]; i++) begin
      if (mact[d][i]) begin
        nx = mx[d][i] - int'(BULLET_STEP_X);
        ny = my[d][i] + mdir[d][i] * int'(BULLET_STEP_Y);
        if (ny > lim) ny = lim;
        if (ny < -lim) ny = -lim;
        mx[d][i] = wrap11(nx);
        my[d][i] = wrap10(ny);
        if ((nx - int'(BULLET_X) < xp + int'(PLAYER_X)) && (nx + int'(BULLET_X) > xp - int'(PLAYER_X)) &&
            !(ny - int'(BULLET_Y) > yp + h) && !(ny + int'(BULLET_Y) < yp - h)) begin
          mact[d][i] = 1'b0;
          mhit[d][i] = 1'b1;
        end else if (nx < int'(BULLET_X) - int'(MAP_X)) begin
          mact[d][i] = 1'b0;
        end
      end
    end
    if (attack && !defend && mcd[d] == 0 && fr >= 0) begin
      mx[d][fr]   = wrap11(int'(xEnemy) - int'(PLAYER_X) - int'(BULLET_X));
      my[d][fr]   = int'(yEnemy);
      mact[d][fr] = 1'b1;
`ifdef BULLET_AIM_EN
      mdir[d][fr] = (yp > int'(yEnemy)) ? 1 : (yp < int'(yEnemy)) ? -1 : 0;
`else
      mdir[d][fr] = 0;
`endif
      mcd[d] = CDM[d];
    end else if (mcd[d] > 0) begin
      mcd[d] = mcd[d] - 1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (!rst_n) model_ok = 1'b1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int xa(input int i); return int'($signed(x_a[11*i +: 11])); endfunction
  function automatic int ya(input int i); return int'($signed(y_a[10*i +: 10])); endfunction
  function automatic int xb(input int i); return int'($signed(x_b[11*i +: 11])); endfunction
  function automatic int yb(input int i); return int'($signed(y_b[10*i +: 10])); endfunction

  // ---------------- per-cycle compare against the model
  always @(negedge clk) begin
    if (model_ok) begin
      int ea, ha, eb, hb;
      ea = 0; ha = 0; eb = 0; hb = 0;
      for (int i = 0; i < 4; i++) begin
        ea |= int'(mact[0][i]) << i;
        ha |= int'(mhit[0][i]) << i;
        chk($sformatf("a_x%0d", i), xa(i), mx[0][i]);
        chk($sformatf("a_y%0d", i), ya(i), my[0][i]);
      end
      for (int i = 0; i < 2; i++) begin
        eb |= int'(mact[1][i]) << i;
        hb |= int'(mhit[1][i]) << i;
        chk($sformatf("b_x%0d", i), xb(i), mx[1][i]);
        chk($sformatf("b_y%0d", i), yb(i), my[1][i]);
      end
      chk("a_isE", int'(isE_a), ea);
      chk("a_hitMask", int'(hm_a), ha);
      chk("a_isHit", int'(ih_a), int'(ha != 0));
      chk("b_isE", int'(isE_b), eb);
      chk("b_hitMask", int'(hm_b), hb);
      chk("b_isHit", int'(ih_b), int'(hb != 0));
      if (ih_a) hits_a++;
      if (ih_b) begin
        hits_b++;
        last_hm_b = hm_b;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    hits_a = 0;
    hits_b = 0;
    last_hm_b = '0;
  endtask

  initial begin
    // reset with attack and tick held
    rst_n = 1'b0; tick = 1'b1; attack = 1'b1;
    xEnemy = 11'sd300; yEnemy = 10'sd50; xPlayer = -11'sd1000; yPlayer = -10'sd400;
    cycles(2);
    chk("rst_isE_a", int'(isE_a), 0);
    chk("rst_isE_b", int'(isE_b), 0);
    chk("rst_x_zero", int'(x_a == '0 && y_a == '0), 1);
    chk("rst_isHit", int'(ih_a | ih_b), 0);

    // guarding suppresses every spawn
    rst_n = 1'b1; defend = 1'b1;
    cycles(10);
    chk("defend_isE_a", int'(isE_a), 0);
    chk("defend_isE_b", int'(isE_b), 0);

    // cooldown spacing and pool fill
    defend = 1'b0;
    cycles(1);
    chk("spawn_x0", xa(0), 280);
    chk("spawn_y0", ya(0), 50);
    chk("spawn_isE_a", int'(isE_a), 1);
    cycles(9);
    chk("cd_isE_a", int'(isE_a), 3);
    chk("cd_x0_a", xa(0), 208);
    chk("cd_x1_a", xa(1), 248);
    chk("full_isE_b", int'(isE_b), 3);

    // map exit of slot 0 and refill on the following tick
    cycles(101);
    chk("exit_isE_b", int'(isE_b), 2);
    chk("exit_x0_b", xb(0), -600);
    chk("exit_nohit", hits_b, 0);
    cycles(1);
    chk("refill_isE_b", int'(isE_b), 1);
    chk("refill_x0_b", xb(0), 280);

    // squatting player lets a bullet through
    do_reset();
    xEnemy = 11'sd200; yEnemy = 10'sd21; xPlayer = '0; yPlayer = '0; isQ = 1'b1;
    attack = 1'b1;
    cycles(1);
    attack = 1'b0;
    cycles(40);
`ifndef BULLET_AIM_EN
    chk("squat_nohit_a", hits_a, 0);
    chk("squat_nohit_b", hits_b, 0);
    chk("squat_alive_a", int'(isE_a), 1);
`endif

    // standing player: two bullets crossing together
    do_reset();
    isQ = 1'b0; xEnemy = 11'sd200; attack = 1'b1;
    cycles(1);
    xEnemy = 11'sd192;
    cycles(1);
    attack = 1'b0;
    cycles(30);
    chk("dual_hit_cycles_b", hits_b, 1);
    chk("dual_hitMask_b", int'(last_hm_b), 3);
    chk("dual_cleared_b", int'(isE_b), 0);
    chk("stand_hit_a", hits_a, 1);

`ifdef BULLET_AIM_EN
    do_reset();
    xPlayer = -11'sd1000; yEnemy = '0; yPlayer = 10'sd100; attack = 1'b1;
    cycles(1);
    attack = 1'b0;
    cycles(3);
    chk("aim_y_a", ya(0), 6);
`endif

    // randomized play
    for (int c = 0; c < 4000; c++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      tick    = ($urandom_range(0, 3) != 0);
      attack  = 1'($urandom_range(0, 1));
      defend  = ($urandom_range(0, 4) == 0);
      isQ     = 1'($urandom_range(0, 1));
      xEnemy  = 11'(int'($urandom_range(100, 500)));
      xPlayer = 11'(int'($urandom_range(0, 600)) - 400);
      yEnemy  = 10'(int'($urandom_range(0, 600)) - 300);
      yPlayer = 10'(int'(yEnemy) + int'($urandom_range(0, 80)) - 40);
      cycles(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
